// File: rtl/elbeth_exs_muldiv_pkg.sv
// Shared elbeth definitions for the EXS multiply/divide unit: M-extension op
// encodings, FSM state encodings and small operand-classification helpers.
package elbeth_exs_muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  // Divide/remainder ops all have bit 2 set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Operand A is interpreted as signed.
  function automatic logic op_a_signed(input logic [2:0] op);
    logic res;
    case (op)
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM: res = 1'b1;
      default:                                           res = 1'b0;
    endcase
    return res;
  endfunction

  // Operand B is interpreted as signed.
  function automatic logic op_b_signed(input logic [2:0] op);
    logic res;
    case (op)
      MULDIV_MULH, MULDIV_DIV, MULDIV_REM: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  // Magnitude of a value known to be negative when neg is set.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/elbeth_exs_muldiv_if.sv
// EXS-stage <-> multiply/divide unit handshake. The pipeline side is the
// master (issues ops, flushes); the muldiv unit is the slave.
interface elbeth_exs_muldiv_if;
  logic        exs_muldiv_start;
  logic [2:0]  exs_muldiv_op;
  logic [31:0] exs_rs1_data;
  logic [31:0] exs_rs2_data;
  logic        ctrl_flush;
  logic        muldiv_stall;
  logic        muldiv_done;
  logic [31:0] muldiv_result;

  modport master (
    output exs_muldiv_start, exs_muldiv_op, exs_rs1_data, exs_rs2_data, ctrl_flush,
    input  muldiv_stall, muldiv_done, muldiv_result
  );

  modport slave (
    input  exs_muldiv_start, exs_muldiv_op, exs_rs1_data, exs_rs2_data, ctrl_flush,
    output muldiv_stall, muldiv_done, muldiv_result
  );
endinterface

// File: rtl/elbeth_exs_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder is shifted left taking the next dividend bit from the
// top of the quotient register; the new quotient bit enters at the bottom.
module elbeth_exs_divider_step
  import elbeth_exs_muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtract; keep the difference only when it does not go negative.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/elbeth_exs_muldiv.sv
// EXS-stage iterative RV32M multiply/divide unit. Works on operand magnitudes
// (radix-2 shift-add multiply, restoring divide) and fixes up the sign when
// the result is written. Divide-by-zero and signed overflow finish in one cycle.
// Build option: define ELBETH_MUL_FAST_EN for a single-cycle multiplier path.
module elbeth_exs_muldiv
  import elbeth_exs_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  elbeth_exs_muldiv_if.slave  bus
);

  muldiv_state_e state, state_next;

  logic [2:0]      op_q,     op_n;
  logic [XLEN-1:0] opnd_q,   opnd_n;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_hi,   acc_hi_n; // product high / partial remainder
  logic [XLEN-1:0] acc_lo,   acc_lo_n; // multiplier-product low / quotient
  logic            neg_q,    neg_n;
  logic [4:0]      count,    count_n;
  logic [XLEN-1:0] result,   result_n;
  logic            done,     done_n;

  logic            in_div, a_neg, b_neg, div_zero, div_ovf, fast_mul;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_hi, div_lo, step_hi, step_lo;
  logic [63:0]     prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_res;

  // Incoming operand classification (only consumed in IDLE).
  assign in_div   = op_is_div(bus.exs_muldiv_op);
  assign a_neg    = op_a_signed(bus.exs_muldiv_op) & bus.exs_rs1_data[31];
  assign b_neg    = op_b_signed(bus.exs_muldiv_op) & bus.exs_rs2_data[31];
  assign a_abs    = mag(bus.exs_rs1_data, a_neg);
  assign b_abs    = mag(bus.exs_rs2_data, b_neg);
  assign div_zero = in_div && (bus.exs_rs2_data == 32'd0);
  assign div_ovf  = ((bus.exs_muldiv_op == MULDIV_DIV) || (bus.exs_muldiv_op == MULDIV_REM)) &&
                    (bus.exs_rs1_data == 32'h8000_0000) && (bus.exs_rs2_data == 32'hFFFF_FFFF);

`ifdef ELBETH_MUL_FAST_EN
  logic [32:0] fast_a, fast_b;
  logic [63:0] fast_prod;
  assign fast_a    = {op_a_signed(bus.exs_muldiv_op) & bus.exs_rs1_data[31], bus.exs_rs1_data};
  assign fast_b    = {op_b_signed(bus.exs_muldiv_op) & bus.exs_rs2_data[31], bus.exs_rs2_data};
  // Sign-extended 33x33 multiply; the low 64 bits are the exact product.
  assign fast_prod = {{31{fast_a[32]}}, fast_a} * {{31{fast_b[32]}}, fast_b};
  assign fast_res  = (bus.exs_muldiv_op == MULDIV_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  assign fast_mul  = !in_div;
`else
  assign fast_res  = 32'd0;
  assign fast_mul  = 1'b0;
`endif

  // Shift-add multiply step: add multiplicand when the low multiplier bit is set.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : 33'd0);

  elbeth_exs_divider_step u_div_step (
    .rem_in  (acc_hi),
    .quo_in  (acc_lo),
    .divisor (opnd_q),
    .rem_out (div_hi),
    .quo_out (div_lo)
  );

  assign step_hi = op_is_div(op_q) ? div_hi : mul_sum[XLEN:1];
  assign step_lo = op_is_div(op_q) ? div_lo : {mul_sum[0], acc_lo[XLEN-1:1]};

  // Sign correction and word selection for the result of the final step.
  always_comb begin
    prod_fix = neg_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
    quo_fix  = neg_q ? (32'd0 - step_lo) : step_lo;
    rem_fix  = neg_q ? (32'd0 - step_hi) : step_hi;
    case (op_q)
      MULDIV_MUL:                              final_res = prod_fix[31:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: final_res = prod_fix[63:32];
      MULDIV_DIV, MULDIV_DIVU:                 final_res = quo_fix;
      MULDIV_REM, MULDIV_REMU:                 final_res = rem_fix;
      default:                                 final_res = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: begin
        if (bus.ctrl_flush) begin
          state_next = MD_IDLE;
        end else if (bus.exs_muldiv_start) begin
          state_next = (div_zero || div_ovf || fast_mul) ? MD_DONE : MD_BUSY;
        end else begin
          state_next = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (bus.ctrl_flush) begin
          state_next = MD_IDLE;
        end else if (count == 5'd31) begin
          state_next = MD_DONE;
        end else begin
          state_next = MD_BUSY;
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Datapath next values: capture in IDLE, iterate in BUSY, write result on entry to DONE.
  always_comb begin
    op_n     = op_q;
    opnd_n   = opnd_q;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    neg_n    = neg_q;
    count_n  = count;
    result_n = result;
    done_n   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (!bus.ctrl_flush && bus.exs_muldiv_start) begin
          op_n     = bus.exs_muldiv_op;
          opnd_n   = in_div ? b_abs : a_abs;
          acc_hi_n = 32'd0;
          acc_lo_n = in_div ? a_abs : b_abs;
          neg_n    = (in_div && bus.exs_muldiv_op[1]) ? a_neg : (a_neg ^ b_neg);
          count_n  = 5'd0;
          if (div_zero) begin
            result_n = bus.exs_muldiv_op[1] ? bus.exs_rs1_data : 32'hFFFF_FFFF;
            done_n   = 1'b1;
          end else if (div_ovf) begin
            result_n = bus.exs_muldiv_op[1] ? 32'd0 : 32'h8000_0000;
            done_n   = 1'b1;
          end else if (fast_mul) begin
            result_n = fast_res;
            done_n   = 1'b1;
          end else begin
            done_n   = 1'b0;
          end
        end else begin
          done_n = 1'b0;
        end
      end
      MD_BUSY: begin
        if (!bus.ctrl_flush) begin
          acc_hi_n = step_hi;
          acc_lo_n = step_lo;
          count_n  = count + 5'd1;
          if (count == 5'd31) begin
            result_n = final_res;
            done_n   = 1'b1;
          end else begin
            done_n   = 1'b0;
          end
        end else begin
          done_n = 1'b0;
        end
      end
      MD_DONE: done_n = 1'b0;
      default: done_n = 1'b0;
    endcase
  end

  // Datapath and output registers; reset clears everything mid-operation too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 3'd0;
      opnd_q <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      neg_q  <= 1'b0;
      count  <= 5'd0;
      result <= 32'd0;
      done   <= 1'b0;
    end else begin
      op_q   <= op_n;
      opnd_q <= opnd_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      neg_q  <= neg_n;
      count  <= count_n;
      result <= result_n;
      done   <= done_n;
    end
  end

  // Stall is combinational so the pipeline advances on the DONE edge.
  assign bus.muldiv_stall  = rst & bus.exs_muldiv_start & (state != MD_DONE);
  assign bus.muldiv_done   = done;
  assign bus.muldiv_result = result;

endmodule
